// File: rtl/system_widths_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_widths_pkg
// Description : System-wide bus widths and the MIU arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package system_widths_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;

  // Arbiter FSM: at most one cache transaction in flight at any time
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin priority pick. Returns the first asserted valid
//               bit at or after ptr, wrapping modulo N, as one-hot + index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Rotate valid so that bit 0 is the pointer position, scan for the first
  // set bit, then add the pointer back to recover the absolute index.
  always_comb begin
    logic [N-1:0]   w_rot;
    logic [IDX_W:0] w_sum;
    logic           w_found;
    w_rot   = N'({valid, valid} >> ptr);
    w_sum   = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, ptr} + (IDX_W+1)'(k);
        if (w_sum >= (IDX_W+1)'(N)) begin
          w_sum = w_sum - (IDX_W+1)'(N);
        end
        idx = IDX_W'(w_sum);
      end
    end
    any   = w_found;
    grant = w_found ? (N'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/miu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : miu_arbiter
// Description : Round-robin arbiter sharing one cache port among NUM_REQ MIU
//               requesters. One transaction in flight; payload registered at
//               acceptance, response data passed straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module miu_arbiter
  import system_widths_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_write,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [DATA_WIDTH-1:0]                resp_data,
  output logic                                 cache_req_valid,
  input  logic                                 cache_req_ready,
  output logic                                 cache_req_we,
  output logic [ADDR_WIDTH-1:0]                cache_req_addr,
  output logic [DATA_WIDTH-1:0]                cache_req_write,
  input  logic                                 cache_resp_valid,
  input  logic [DATA_WIDTH-1:0]                cache_resp_data
);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_owner;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_write;
  logic                   r_cache_req_valid;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_any;
  logic [IDX_W-1:0]       w_next_ptr;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_grant_idx),
    .any   (w_any)
  );

  // Priority moves to the requester just after the one that was served
  assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ-1)) ? '0 : r_owner + IDX_W'(1);

  // Arbitration FSM with registered cache-side payload and request valid
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state           <= IDLE;
      r_rr_ptr          <= '0;
      r_owner           <= '0;
      r_we              <= 1'b0;
      r_addr            <= '0;
      r_write           <= '0;
      r_cache_req_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner           <= w_grant_idx;
            r_we              <= req_we[w_grant_idx];
            r_addr            <= req_addr[w_grant_idx];
            r_write           <= req_write[w_grant_idx];
            r_cache_req_valid <= 1'b1;
            r_state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (cache_req_ready) begin
            r_cache_req_valid <= 1'b0;
            r_state           <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (cache_resp_valid) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_cache_req_valid <= 1'b0;
          r_state           <= IDLE;
        end
      endcase
    end
  end

  // Grant is combinational in IDLE only; held low while reset is asserted
  assign req_ready = ((r_state == IDLE) && resetN) ? w_grant : '0;

  // Responses are routed to the owner only while a response is awaited
  assign resp_valid = ((r_state == WAIT_RESP) && cache_resp_valid) ?
                      (NUM_REQ'(1) << r_owner) : '0;
  assign resp_data  = (r_state == WAIT_RESP) ? cache_resp_data : '0;

  assign cache_req_valid = r_cache_req_valid;
  assign cache_req_we    = r_we;
  assign cache_req_addr  = r_addr;
  assign cache_req_write = r_write;

endmodule
`default_nettype wire

// File: tb/tb_miu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_miu_arbiter
// Description : Self-checking bench for miu_arbiter: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miu_arbiter;
  import system_widths_pkg::*;

  localparam int N = 4;

  logic                               clk = 1'b0;
  logic                               resetN;
  logic [N-1:0]                       req_valid;
  logic [N-1:0]                       req_ready;
  logic [N-1:0]                       req_we;
  logic [N-1:0][ADDR_WIDTH-1:0]       req_addr;
  logic [N-1:0][DATA_WIDTH-1:0]       req_write;
  logic [N-1:0]                       resp_valid;
  logic [DATA_WIDTH-1:0]              resp_data;
  logic                               cache_req_valid;
  logic                               cache_req_ready;
  logic                               cache_req_we;
  logic [ADDR_WIDTH-1:0]              cache_req_addr;
  logic [DATA_WIDTH-1:0]              cache_req_write;
  logic                               cache_resp_valid;
  logic [DATA_WIDTH-1:0]              cache_resp_data;

  int checks = 0;
  int passes = 0;

  miu_arbiter #(.NUM_REQ(N)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_write        (req_write),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .cache_req_valid  (cache_req_valid),
    .cache_req_ready  (cache_req_ready),
    .cache_req_we     (cache_req_we),
    .cache_req_addr   (cache_req_addr),
    .cache_req_write  (cache_req_write),
    .cache_resp_valid (cache_resp_valid),
    .cache_resp_data  (cache_resp_data)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: accepted-now request by `who`, ready cache, 1-cycle response
  task automatic complete_txn(input int who);
    tick();
    req_valid[who]   = 1'b0;
    cache_req_ready  = 1'b1;
    tick();
    cache_resp_valid = 1'b1;
    tick();
    cache_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetN           = 1'b0;
    req_valid        = '0;
    req_we           = '0;
    req_addr         = '0;
    req_write        = '0;
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b1;
    cache_resp_data  = 16'hFFFF;
    repeat (3) tick();
    #1;
    checks++;
    if ({req_ready, resp_valid, cache_req_valid, cache_req_we} !== 10'b0)
      $display("FAIL rst_ctrl: got %b expected %b",
               {req_ready, resp_valid, cache_req_valid, cache_req_we}, 10'b0);
    else passes++;
    checks++;
    if (cache_req_addr !== 16'h0)
      $display("FAIL rst_addr: got %h expected %h", cache_req_addr, 16'h0);
    else passes++;
    checks++;
    if (cache_req_write !== 16'h0)
      $display("FAIL rst_write: got %h expected %h", cache_req_write, 16'h0);
    else passes++;
    checks++;
    if (resp_data !== 16'h0)
      $display("FAIL rst_resp_data: got %h expected %h", resp_data, 16'h0);
    else passes++;
    cache_resp_valid = 1'b0;
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid       = 4'b0100;
    req_addr[2]     = 16'h0010;
    req_we[2]       = 1'b0;
    req_write[2]    = 16'h1234;
    cache_req_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100)
      $display("FAIL single_ready: got %b expected %b", req_ready, 4'b0100);
    else passes++;
    tick();
    req_valid   = '0;
    req_addr[2] = 16'hDEAD;
    #1;
    checks++;
    if ({cache_req_valid, cache_req_we, cache_req_addr, req_ready} !== {1'b1, 1'b0, 16'h0010, 4'b0})
      $display("FAIL single_issue: got %h expected %h",
               {cache_req_valid, cache_req_we, cache_req_addr, req_ready},
               {1'b1, 1'b0, 16'h0010, 4'b0});
    else passes++;
    tick();
    cache_resp_valid = 1'b1;
    cache_resp_data  = 16'hBEEF;
    #1;
    checks++;
    if ({resp_valid, resp_data} !== {4'b0100, 16'hBEEF})
      $display("FAIL single_resp: got %h expected %h", {resp_valid, resp_data}, {4'b0100, 16'hBEEF});
    else passes++;
    tick();
    cache_resp_valid = 1'b0;
  endtask

  // Pointer is 3 after the single test; serving requester 1 moves it to 2
  task automatic test_wrap();
    req_valid = 4'b0010;
    complete_txn(1);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000)
      $display("FAIL wrap_first: got %b expected %b", req_ready, 4'b1000);
    else passes++;
    complete_txn(3);
    #1;
    checks++;
    if (req_ready !== 4'b0010)
      $display("FAIL wrap_second: got %b expected %b", req_ready, 4'b0010);
    else passes++;
    complete_txn(1);
  endtask

  task automatic test_spurious_reset();
    cache_resp_valid = 1'b1;
    cache_resp_data  = 16'h5555;
    #1;
    checks++;
    if (resp_valid !== 4'b0)
      $display("FAIL spur_resp: got %b expected %b", resp_valid, 4'b0);
    else passes++;
    tick();
    cache_resp_valid = 1'b0;
    req_valid   = 4'b0100;
    req_addr[2] = 16'h0077;
    #1;
    checks++;
    if (req_ready !== 4'b0100)
      $display("FAIL spur_idle: got %b expected %b", req_ready, 4'b0100);
    else passes++;
    tick();
    req_valid       = '0;
    cache_req_ready = 1'b1;
    tick();
    resetN           = 1'b0;
    cache_resp_valid = 1'b1;
    #1;
    checks++;
    if ({resp_valid, cache_req_valid, cache_req_addr, resp_data} !== 37'b0)
      $display("FAIL midrst_out: got %h expected %h",
               {resp_valid, cache_req_valid, cache_req_addr, resp_data}, 37'b0);
    else passes++;
    tick();
    cache_resp_valid = 1'b0;
    resetN           = 1'b1;
    req_valid        = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL midrst_grant: got %b expected %b", req_ready, 4'b0001);
    else passes++;
  endtask

  // All valid, ready cache, instant response: accept every third cycle
  task automatic test_fairness();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rsp;
    req_valid        = 4'hF;
    cache_req_ready  = 1'b1;
    cache_resp_valid = 1'b1;
    cache_resp_data  = 16'hC0DE;
    for (int c = 0; c < 15; c++) begin
      exp_rdy = '0;
      exp_rsp = '0;
      if (c % 3 == 0) exp_rdy[(c/3) % N] = 1'b1;
      if (c % 3 == 2) exp_rsp[(c/3) % N] = 1'b1;
      #1;
      checks++;
      if ({req_ready, resp_valid, cache_req_valid} !== {exp_rdy, exp_rsp, (c % 3 == 1)})
        $display("FAIL fair_c%0d: got %b expected %b", c,
                 {req_ready, resp_valid, cache_req_valid}, {exp_rdy, exp_rsp, (c % 3 == 1)});
      else passes++;
      tick();
    end
    req_valid        = '0;
    cache_resp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    req_valid       = 4'b0001;
    req_we[0]       = 1'b1;
    req_addr[0]     = 16'hA5A5;
    req_write[0]    = 16'h1357;
    cache_req_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL bp_accept: got %b expected %b", req_ready, 4'b0001);
    else passes++;
    tick();
    req_valid   = 4'hE;
    req_addr[0] = 16'h0000;
    req_write[0] = 16'hFFFF;
    req_we[0]   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({cache_req_valid, cache_req_we, cache_req_addr, cache_req_write, req_ready} !==
          {1'b1, 1'b1, 16'hA5A5, 16'h1357, 4'b0})
        $display("FAIL bp_hold_c%0d: got %h expected %h", c,
                 {cache_req_valid, cache_req_we, cache_req_addr, cache_req_write, req_ready},
                 {1'b1, 1'b1, 16'hA5A5, 16'h1357, 4'b0});
      else passes++;
      tick();
    end
    cache_req_ready = 1'b1;
    tick();
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b1;
    cache_resp_data  = 16'h0F0F;
    #1;
    checks++;
    if ({cache_req_valid, resp_valid, resp_data} !== {1'b0, 4'b0001, 16'h0F0F})
      $display("FAIL bp_resp: got %h expected %h",
               {cache_req_valid, resp_valid, resp_data}, {1'b0, 4'b0001, 16'h0F0F});
    else passes++;
    tick();
    cache_resp_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0010)
      $display("FAIL bp_next: got %b expected %b", req_ready, 4'b0010);
    else passes++;
    req_valid = '0;
  endtask

  // Random traffic: pending requesters persist until served; model tracks pointer
  task automatic test_random();
    logic [N-1:0]            pend;
    logic [N-1:0]            exp_rdy;
    logic [N-1:0]            exp_rsp;
    logic [ADDR_WIDTH-1:0]   addr_m [N];
    logic [DATA_WIDTH-1:0]   data_m [N];
    logic                    we_m   [N];
    logic [DATA_WIDTH-1:0]   rd;
    int                      ptr_m;
    int                      w;
    int                      d;
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    ptr_m  = 0;
    pend   = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          addr_m[i] = ADDR_WIDTH'($urandom);
          data_m[i] = DATA_WIDTH'($urandom);
          we_m[i]   = 1'($urandom);
        end
        req_addr[i]  = addr_m[i];
        req_write[i] = data_m[i];
        req_we[i]    = we_m[i];
      end
      req_valid        = pend;
      cache_req_ready  = 1'b0;
      cache_resp_valid = 1'b0;
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp_rdy)
        $display("FAIL rnd_ready_t%0d: got %b expected %b", t, req_ready, exp_rdy);
      else passes++;
      tick();
      if (w < 0) continue;
      pend[w]      = 1'b0;
      req_valid    = pend;
      req_addr[w]  = ADDR_WIDTH'($urandom);
      req_write[w] = DATA_WIDTH'($urandom);
      d = $urandom_range(0, 3);
      for (int c = 0; c <= d; c++) begin
        cache_req_ready  = (c == d);
        cache_resp_valid = 1'($urandom);
        cache_resp_data  = DATA_WIDTH'($urandom);
        #1;
        checks++;
        if ({cache_req_valid, cache_req_we, cache_req_addr, cache_req_write, req_ready, resp_valid} !==
            {1'b1, we_m[w], addr_m[w], data_m[w], 4'b0, 4'b0})
          $display("FAIL rnd_issue_t%0d: got %h expected %h", t,
                   {cache_req_valid, cache_req_we, cache_req_addr, cache_req_write, req_ready, resp_valid},
                   {1'b1, we_m[w], addr_m[w], data_m[w], 4'b0, 4'b0});
        else passes++;
        tick();
      end
      cache_req_ready = 1'b0;
      d = $urandom_range(0, 3);
      for (int c = 0; c <= d; c++) begin
        rd               = DATA_WIDTH'($urandom);
        cache_resp_valid = (c == d);
        cache_resp_data  = rd;
        exp_rsp = '0;
        if (c == d) exp_rsp[w] = 1'b1;
        #1;
        checks++;
        if ({resp_valid, resp_data, cache_req_valid, req_ready} !== {exp_rsp, rd, 1'b0, 4'b0})
          $display("FAIL rnd_resp_t%0d: got %h expected %h", t,
                   {resp_valid, resp_data, cache_req_valid, req_ready}, {exp_rsp, rd, 1'b0, 4'b0});
        else passes++;
        tick();
      end
      cache_resp_valid = 1'b0;
      ptr_m = (w + 1) % N;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_spurious_reset();
    test_fairness();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/miu_arbiter.md
MIU_ARBITER -- requirements
Module: miu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of MIU requesters sharing one cache port (legal 2..8).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_REQ), owner index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester request accepted.
REQ-007 SHALL have port req_we  input  NUM_REQ  per-requester write enable.
REQ-008 SHALL have port req_addr  input  NUM_REQ x ADDR_WIDTH  per-requester address.
REQ-009 SHALL have port req_write  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-010 SHALL have port resp_valid  output  NUM_REQ  per-requester response valid.
REQ-011 SHALL have port resp_data  output  DATA_WIDTH  response data, shared by all requesters.
REQ-012 SHALL have ports cache_req_valid/cache_req_ready/cache_req_we  out/in/out  1  cache-side request handshake.
REQ-013 SHALL have ports cache_req_addr/cache_req_write  output  ADDR_WIDTH/DATA_WIDTH  cache-side payload.
REQ-014 SHALL have ports cache_resp_valid/cache_resp_data  input  1/DATA_WIDTH  cache-side response.

Function
REQ-015 SHALL implement an FSM with states IDLE, ISSUE, WAIT_RESP; at most one transaction in flight.
REQ-016 IDLE: winner = first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-017 IDLE with any req_valid: req_ready[winner]=1 combinationally, all other req_ready=0; owner, we, addr, write data latched into registers; next state ISSUE.
REQ-018 IDLE with no req_valid: all req_ready=0; stay in IDLE.
REQ-019 req_ready SHALL be 0 in ISSUE and WAIT_RESP; requesters hold valid and payload until ready.
REQ-020 ISSUE: cache_req_valid=1 with the registered payload; payload stable until cache_req_ready=1; then next state WAIT_RESP.
REQ-021 cache_req_valid SHALL be 0 outside ISSUE.
REQ-022 WAIT_RESP: resp_valid[owner]=cache_resp_valid, others 0; resp_data=cache_resp_data (pass-through).
REQ-023 WAIT_RESP with cache_resp_valid=1: rr_ptr <= (owner+1) mod NUM_REQ; next state IDLE.
REQ-024 cache_resp_valid outside WAIT_RESP SHALL be ignored: no resp_valid, no state change.
REQ-025 Minimum latency with an always-ready cache: accept in cycle 0, cache_req_valid in cycle 1, earliest resp_valid in cycle 2, next accept in cycle 3.
REQ-026 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transactions.
REQ-027 A requester dropping valid before ready is a protocol violation; behaviour is unspecified, but the FSM SHALL NOT deadlock.

Reset
REQ-028 On resetN=0 (any state, including mid-transaction): state=IDLE, rr_ptr=0, owner=0, payload registers=0, all outputs 0; any in-flight transaction is dropped.
REQ-029 The first cycle after reset deassertion SHALL arbitrate normally from rr_ptr=0.

Structure
REQ-030 ADDR_WIDTH and DATA_WIDTH SHALL come from system_widths_pkg; the FSM state enum arb_state_t SHALL be added to that package.
REQ-031 The round-robin priority pick SHALL be a sub-module rr_pick (inputs valid vector and pointer; outputs one-hot grant and index).

Verification
REQ-032 Single request: req_valid=4'b0100, addr=0x10, we=0 -> req_ready[2] in cycle 0, cache_req_addr=0x10 in cycle 1, resp_valid=4'b0100 with cache data 0xBEEF.
REQ-033 All four valid continuously, cache always ready, 1-cycle response -> grant order 0,1,2,3,0; one accept every 3 cycles.
REQ-034 Cache backpressure: cache_req_ready low for 5 cycles in ISSUE -> cache_req_addr/write/we stable, req_ready all 0, grant proceeds after ready.
REQ-035 Requesters 1 and 3 valid, rr_ptr=2 -> requester 3 granted first, then 1 (wrap-around).
REQ-036 Spurious cache_resp_valid in IDLE -> resp_valid stays 0 and state stays IDLE; resetN pulsed in WAIT_RESP -> outputs 0, next grant goes to requester 0.
